// File: rtl/pipeline_pkg.sv
// Shared pipeline-control definitions.
//   state_t         : hazard controller FSM states
//   FWD_RF/W/M      : forwarding mux select encodings
//   RESULT_SRC_LOAD : E_result_src value marking a load in execute
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for one execute-stage source operand.
// Ports:
//   rs                      : execute-stage source register
//   M_rd, M_RegWrite        : memory-stage destination / write enable
//   W_rd, W_RegWrite        : write-back-stage destination / write enable
//   sel                     : FWD_M, FWD_W or FWD_RF
// The memory stage wins because it holds the younger result; x0 never forwards.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] M_rd,
    input  logic       M_RegWrite,
    input  logic [4:0] W_rd,
    input  logic       W_RegWrite,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (M_RegWrite && (M_rd != 5'd0) && (M_rd == rs))
            sel = FWD_M;
        else if (W_RegWrite && (W_rd != 5'd0) && (W_rd == rs))
            sel = FWD_W;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubble flushes, operand
// forwarding selects and a saturating count of frozen-front-end cycles.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   D_rs1/D_rs2                    : decode source regs
//   E_rs1/E_rs2/E_rd, E_result_src : execute regs, load marker
//   E_pc_src                       : taken branch/jump in execute
//   E_div_start, div_done          : multi-cycle divide handshake
//   M_rd/W_rd, M_RegWrite/W_RegWrite : forwarding sources
//   M_mem_req, mem_ready           : data memory handshake
//   F_en..M_W_en                   : stage-register enables
//   F_D_flush, D_E_flush, M_W_flush : bubble inserts
//   fwd_a, fwd_b                   : operand forwarding selects
//   stall_cycles                   : saturating stall counter
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           D_rs1,
    input  logic [4:0]           D_rs2,
    input  logic [4:0]           E_rs1,
    input  logic [4:0]           E_rs2,
    input  logic [4:0]           E_rd,
    input  logic [1:0]           E_result_src,
    input  logic                 E_pc_src,
    input  logic                 E_div_start,
    input  logic                 div_done,
    input  logic [4:0]           M_rd,
    input  logic [4:0]           W_rd,
    input  logic                 M_RegWrite,
    input  logic                 W_RegWrite,
    input  logic                 M_mem_req,
    input  logic                 mem_ready,
    output logic                 F_en,
    output logic                 F_D_en,
    output logic                 D_E_en,
    output logic                 E_M_en,
    output logic                 M_W_en,
    output logic                 F_D_flush,
    output logic                 D_E_flush,
    output logic                 M_W_flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    // DATA_WIDTH only exists so every pipeline block instantiates alike.
    if (DATA_WIDTH > 0) begin : g_data_width_ok
    end

    state_t state, state_next;
    logic   mem_miss, load_use, ctl_check;
    logic [1:0] sel_a, sel_b;

    assign mem_miss = M_mem_req && !mem_ready;
    assign load_use = (E_result_src == RESULT_SRC_LOAD) && (E_rd != 5'd0) &&
                      ((E_rd == D_rs1) || (E_rd == D_rs2));

    fwd_unit u_fwd_a (
        .rs(E_rs1), .M_rd(M_rd), .M_RegWrite(M_RegWrite),
        .W_rd(W_rd), .W_RegWrite(W_RegWrite), .sel(sel_a)
    );
    fwd_unit u_fwd_b (
        .rs(E_rs2), .M_rd(M_rd), .M_RegWrite(M_RegWrite),
        .W_rd(W_rd), .W_RegWrite(W_RegWrite), .sel(sel_b)
    );

    assign fwd_a = rst ? FWD_RF : sel_a;
    assign fwd_b = rst ? FWD_RF : sel_b;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        F_en       = 1'b1;
        F_D_en     = 1'b1;
        D_E_en     = 1'b1;
        E_M_en     = 1'b1;
        M_W_en     = 1'b1;
        F_D_flush  = 1'b0;
        D_E_flush  = 1'b0;
        M_W_flush  = 1'b0;
        ctl_check  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        {F_en, F_D_en, D_E_en, E_M_en, M_W_en} = 5'b00000;
                        M_W_flush  = 1'b1;
                        state_next = MEM_WAIT;
                    end else if (E_div_start) begin
                        {F_en, F_D_en, D_E_en, E_M_en} = 4'b0000;
                        M_W_flush  = 1'b1;
                        state_next = DIV_WAIT;
                    end else begin
                        ctl_check = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_next = RUN;
                        ctl_check  = 1'b1;
                    end else begin
                        {F_en, F_D_en, D_E_en, E_M_en, M_W_en} = 5'b00000;
                        M_W_flush = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        state_next = RUN;
                        ctl_check  = 1'b1;
                    end else begin
                        // Write-back keeps draining; the bubble stops the
                        // retiring instruction from writing back twice.
                        {F_en, F_D_en, D_E_en, E_M_en} = 4'b0000;
                        M_W_flush = 1'b1;
                    end
                end
                default: state_next = RUN;
            endcase

            // A taken branch squashes the load's consumer anyway, so it
            // overrides the load-use stall.
            if (ctl_check) begin
                if (E_pc_src) begin
                    F_D_flush = 1'b1;
                    D_E_flush = 1'b1;
                end else if (load_use) begin
                    F_en      = 1'b0;
                    F_D_en    = 1'b0;
                    D_E_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (!F_en && (stall_cycles != {CNT_WIDTH{1'b1}}))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
